// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers.
// Holds the stage FSM encoding, the NOP encoding and the D/E bundle field
// offsets so producers and consumers pack and unpack the payload identically.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0;

  // D/E bundle layout, LSB first: cmp flag, then rt, rs, ext, pc, instr.
  localparam int DE_CMP   = 0;
  localparam int DE_RT    = 1;
  localparam int DE_RS    = 33;
  localparam int DE_EXT   = 65;
  localparam int DE_PC    = 97;
  localparam int DE_INSTR = 129;
  localparam int DE_W     = 161;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance debug.
// Ports: clk/reset (sync, active-high), inc (count enable), clr (sync clear,
// wins over inc), count (holds at all-ones instead of wrapping).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, flush and stall counter.
// Latency: 1 cycle in_data -> out_data. Backpressure: in_ready is a pure state
// decode (drops only when the skid entry is occupied), never combinational on out_ready.
// Ports: clk, reset (sync, active-high), flush (kills both entries),
//   in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data downstream,
//   occupancy (0..2 entries), stall_cnt (saturating out_valid & !out_ready cycles),
//   clr_cnt (sync clear of stall_cnt).
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W      = DE_W,
  parameter bit BUBBLE_ZERO = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_cnt
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] skid_data;
  logic              skid_valid;
  logic              accept;
  logic              drain;
  logic              stall_inc;

  // Datapath controls decoded from state and handshakes.
  logic ld_main_in;
  logic ld_main_skid;
  logic clr_main;
  logic ld_skid;
  logic clr_skid;

  // Status is a direct decode of the state register, so every output is
  // register-derived.
  assign out_valid  = (state != ST_EMPTY);
  assign skid_valid = (state == ST_FULL);
  assign in_ready   = !skid_valid;
  assign occupancy  = {1'b0, out_valid} + {1'b0, skid_valid};

  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign stall_inc = out_valid & !out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_nxt = ST_BUSY;
        ST_BUSY: begin
          if (accept && !drain)      state_nxt = ST_FULL;
          else if (!accept && drain) state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (drain) state_nxt = ST_BUSY;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Output (datapath control) logic
  always_comb begin
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    clr_main     = 1'b0;
    ld_skid      = 1'b0;
    clr_skid     = 1'b0;
    case (state)
      ST_EMPTY: ld_main_in = accept;
      ST_BUSY: begin
        ld_main_in = accept & drain;
        ld_skid    = accept & !drain;
        clr_main   = !accept & drain;
      end
      ST_FULL: begin
        ld_main_skid = drain;
        clr_skid     = drain;
      end
      default: ;
    endcase
  end

  // Payload registers. Flush discards any same-cycle accept; with BUBBLE_ZERO
  // an emptied entry reads as the NOP encoding (all zeros).
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      skid_data <= '0;
    end else if (flush) begin
      if (BUBBLE_ZERO) begin
        out_data  <= '0;
        skid_data <= '0;
      end
    end else begin
      if (ld_main_in) begin
        out_data <= in_data;
      end else if (ld_main_skid) begin
        out_data <= skid_data;
      end else if (clr_main && BUBBLE_ZERO) begin
        out_data <= '0;
      end

      if (ld_skid) begin
        skid_data <= in_data;
      end else if (clr_skid && BUBBLE_ZERO) begin
        skid_data <= '0;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .clr   (clr_cnt),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, hand-written corner
// sequences (counter saturation, drain after stall, reset mid-FULL) and a
// random valid/ready run against a queue scoreboard.
module tb_pipe_stage_skid;

  localparam int DW = 16;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic          clr_cnt;
  logic [DW-1:0] in_data;

  // default instance: BUBBLE_ZERO=1, CNT_W=16
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  // BUBBLE_ZERO=0 instance
  logic          b0_in_ready;
  logic          b0_out_valid;
  logic [DW-1:0] b0_out_data;
  logic [1:0]    b0_occupancy;
  logic [15:0]   b0_stall_cnt;

  // CNT_W=4 instance
  logic          c4_in_ready;
  logic          c4_out_valid;
  logic [DW-1:0] c4_out_data;
  logic [1:0]    c4_occupancy;
  logic [3:0]    c4_stall_cnt;

  int checks = 0;
  int errors = 0;
  bit inv_en = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE_ZERO(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .clr_cnt(clr_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE_ZERO(1'b0), .CNT_W(16)) u_bz0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b0_in_ready), .in_data(in_data),
    .out_valid(b0_out_valid), .out_ready(out_ready), .out_data(b0_out_data),
    .occupancy(b0_occupancy), .stall_cnt(b0_stall_cnt), .clr_cnt(clr_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE_ZERO(1'b1), .CNT_W(4)) u_c4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(c4_in_ready), .in_data(in_data),
    .out_valid(c4_out_valid), .out_ready(out_ready), .out_data(c4_out_data),
    .occupancy(c4_occupancy), .stall_cnt(c4_stall_cnt), .clr_cnt(clr_cnt)
  );

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          fl;
    logic          clr;
    logic          ov;
    logic [DW-1:0] od;
    logic          ir;
    logic [1:0]    occ;
    logic [15:0]   st;
    logic [DW-1:0] od_b0;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // skid entry occupied without the main entry would break FIFO order
  always @(negedge clk) begin
    if (inv_en && !reset) begin
      check("inv_skid_implies_out", 32'(u_dut.skid_valid && !u_dut.out_valid), 32'd0);
    end
  end

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_d;
  logic          acc;
  logic          drn;

  initial begin
    //            iv id         rdy fl clr   ov od         ir occ    st      od_b0
    tbl[0]  = '{H, 16'hABCD, H, L, L,   H, 16'hABCD, H, 2'd1, 16'd0, 16'hABCD};
    tbl[1]  = '{H, 16'hABCE, H, L, L,   H, 16'hABCE, H, 2'd1, 16'd0, 16'hABCE};
    tbl[2]  = '{H, 16'hABCF, H, L, L,   H, 16'hABCF, H, 2'd1, 16'd0, 16'hABCF};
    tbl[3]  = '{L, 16'h0000, H, L, L,   L, 16'h0000, H, 2'd0, 16'd0, 16'hABCF};
    tbl[4]  = '{H, 16'h00A1, L, L, L,   H, 16'h00A1, H, 2'd1, 16'd0, 16'h00A1};
    tbl[5]  = '{H, 16'h00B2, L, L, L,   H, 16'h00A1, L, 2'd2, 16'd1, 16'h00A1};
    tbl[6]  = '{H, 16'h00C3, L, L, L,   H, 16'h00A1, L, 2'd2, 16'd2, 16'h00A1};
    tbl[7]  = '{H, 16'h00C3, L, L, L,   H, 16'h00A1, L, 2'd2, 16'd3, 16'h00A1};
    tbl[8]  = '{H, 16'h00C3, H, L, L,   H, 16'h00B2, H, 2'd1, 16'd3, 16'h00B2};
    tbl[9]  = '{H, 16'h00C3, H, L, L,   H, 16'h00C3, H, 2'd1, 16'd3, 16'h00C3};
    tbl[10] = '{L, 16'h0000, H, L, L,   L, 16'h0000, H, 2'd0, 16'd3, 16'h00C3};
    tbl[11] = '{H, 16'h00D1, L, L, L,   H, 16'h00D1, H, 2'd1, 16'd3, 16'h00D1};
    tbl[12] = '{H, 16'h00D2, L, L, L,   H, 16'h00D1, L, 2'd2, 16'd4, 16'h00D1};
    tbl[13] = '{H, 16'h00D3, L, H, L,   L, 16'h0000, H, 2'd0, 16'd5, 16'h00D1};
    tbl[14] = '{L, 16'h0000, H, L, L,   L, 16'h0000, H, 2'd0, 16'd5, 16'h00D1};
    tbl[15] = '{L, 16'h0000, H, L, H,   L, 16'h0000, H, 2'd0, 16'd0, 16'h00D1};
    tbl[16] = '{H, 16'h00E1, H, L, L,   H, 16'h00E1, H, 2'd1, 16'd0, 16'h00E1};
    tbl[17] = '{H, 16'h00E2, H, H, L,   L, 16'h0000, H, 2'd0, 16'd0, 16'h00E1};
    tbl[18] = '{L, 16'h0000, H, L, L,   L, 16'h0000, H, 2'd0, 16'd0, 16'h00E1};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clr_cnt = 1'b0; in_data = '0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    reset = 1'b0;
    inv_en = 1'b1;

    for (int i = 0; i < 19; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
      flush = tbl[i].fl; clr_cnt = tbl[i].clr;
      tick();
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      check($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(tbl[i].od));
      check($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].ir));
      check($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].occ));
      check($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].st));
      check($sformatf("vec%0d_bz0_data", i),  32'(b0_out_data), 32'(tbl[i].od_b0));
      check($sformatf("vec%0d_bz0_valid", i), 32'(b0_out_valid), 32'(tbl[i].ov));
    end
    flush = 1'b0; clr_cnt = 1'b0;

    // 20 cycles of backpressure: first beat fills main, second fills skid.
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 16'h0F00 + 16'(i); out_ready = 1'b0;
      tick();
    end
    check("sat_c16_cnt", 32'(stall_cnt), 32'd19);
    check("sat_c4_cnt", 32'(c4_stall_cnt), 32'd15);
    check("sat_hold_data", 32'(out_data), 32'h0F00);
    check("sat_full_occ", 32'(occupancy), 32'd2);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_c4_cnt", 32'(c4_stall_cnt), 32'd0);
    check("clr_c16_cnt", 32'(stall_cnt), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("rel_data_skid", 32'(out_data), 32'h0F01);
    check("rel_occ", 32'(occupancy), 32'd1);
    tick();
    check("rel_empty_valid", 32'(out_valid), 32'd0);
    check("rel_empty_data", 32'(out_data), 32'd0);

    // reset while FULL
    in_valid = 1'b1; out_ready = 1'b0; in_data = 16'h0111;
    tick();
    in_data = 16'h0222;
    tick();
    check("pre_rst_occ", 32'(occupancy), 32'd2);
    reset = 1'b1;
    tick();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data",  32'(out_data),  32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_occupancy", 32'(occupancy), 32'd0);
    check("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("midrst_skid_data", 32'(u_dut.skid_data), 32'd0);
    reset = 1'b0;
    in_valid = 1'b0;

    // random valid/ready against a FIFO scoreboard
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      #1;
      acc = in_valid & in_ready;
      drn = out_valid & out_ready;
      if (drn) begin
        if (q.size() == 0) begin
          check("rand_spurious_drain", 32'd1, 32'd0);
        end else begin
          exp_d = q.pop_front();
          check("rand_data", 32'(out_data), 32'(exp_d));
        end
      end
      if (acc) q.push_back(in_data);
      tick();
      check("rand_occupancy", 32'(occupancy), 32'(q.size()));
    end

    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          check("tail_spurious_drain", 32'd1, 32'd0);
        end else begin
          exp_d = q.pop_front();
          check("tail_data", 32'(out_data), 32'(exp_d));
        end
      end
      tick();
    end
    check("tail_lossless", 32'(q.size()), 32'd0);
    check("tail_out_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register for the 5-stage MIPS core. Replaces fixed-field stage registers that have only a single enable.
- Carries an opaque DATA_W-bit payload with a valid/ready handshake on both sides.
- A 2-entry skid buffer gives full throughput with a registered in_ready. Adds synchronous flush (branch/exception kill) and a saturating stall counter for performance debug.
- Instantiated between every pair of stages (F/D, D/E, E/M, M/W).

Parameters:
- DATA_W, 161: payload width. Default = instr, PC, ext, rs, rt (5x32) + cmp flag (1).
- BUBBLE_ZERO, 1: 1 = payload register cleared to 0 (NOP encoding) whenever the stage empties or flushes; 0 = payload holds stale value.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous kill of all stage contents
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept; = !skid_valid (register-driven, no combinational path from out_ready)
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  registered payload (main entry)
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating
- clr_cnt  in  1  synchronous clear of stall_cnt

Behaviour:
- Reset values: out_valid=0, out_data=0, skid_valid=0, skid_data=0, occupancy=0, stall_cnt=0, state=EMPTY. in_ready=1 from the first cycle after reset.
- Handshake definitions: accept = in_valid & in_ready; drain = out_valid & out_ready. Latency is 1 cycle, in_data to out_data. Payload is held stable while out_valid & !out_ready.
- State EMPTY (occ 0):
  - accept -> BUSY, main<=in_data.
- State BUSY (occ 1):
  - accept & drain -> BUSY, main<=in_data.
  - accept & !drain -> FULL, skid<=in_data, main held.
  - !accept & drain -> EMPTY; main<=0 if BUBBLE_ZERO.
  - !accept & !drain -> hold.
- State FULL (occ 2): in_ready=0, in_valid ignored.
  - drain -> BUSY, main<=skid; skid<=0 if BUBBLE_ZERO.
  - !drain -> hold.
- Ordering is strict FIFO. No payload is lost or duplicated.
- Priority: reset > flush > normal operation.
  - flush: state->EMPTY, both valids 0; payloads zeroed if BUBBLE_ZERO.
  - A same-cycle accept is discarded. A same-cycle drain still counts as consumed by downstream, which is responsible for gating on its own flush.
- Flush mid-FULL clears both entries. in_ready returns to 1 on the next cycle.
- stall_cnt:
  - +1 each cycle out_valid & !out_ready; saturates at 2^CNT_W-1, no wrap.
  - clr_cnt -> 0. Takes priority over increment.
  - Not cleared by flush.
- Invariant: skid_valid implies out_valid. The bench asserts it.
- occupancy = out_valid + skid_valid, registered-derived.

Decomposition:
- Package pipe_pkg:
  - state typedef {ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2}.
  - NOP constant (32'h0).
  - Bit-offset constants for the D/E bundle (INSTR, PC, EXT, RS, RT, CMP) so producers and consumers pack and unpack identically.
- One natural sub-module: sat_counter (parametrised width, inc, clr, saturating). Reused by other perf counters.

Test Plan:
- Reset, then in_valid=1, in_data=0x...ABCD each cycle, out_ready=1 -> out_valid rises 1 cycle later. One beat per cycle with no bubbles. in_ready stays 1, occupancy=1.
- Stream A,B,C; drop out_ready for 3 cycles after A is presented:
  - B goes to skid, in_ready=0, occupancy=2, stall_cnt=3.
  - On release, out_data sequence is A,B,C.
- From FULL, assert flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, out_data=0 (BUBBLE_ZERO=1), in_ready=1. The flushed input never appears.
- BUBBLE_ZERO=0: drain to EMPTY -> out_data retains the last payload, out_valid=0.
- CNT_W=4, hold stall for 20 cycles -> stall_cnt saturates at 15. Then clr_cnt -> 0 on the next cycle.
- Random valid/ready (10k cycles) vs scoreboard -> in-order and lossless. skid_valid implies out_valid holds every cycle. Reset asserted mid-FULL -> all outputs at reset values next cycle.
